pipe_reg_bank: RTL and testbench
================================

# pipe_reg_bank

Parametrised bank of pipeline registers for the multicycle-to-pipelined CPU datapath. It replaces the fixed four-bar latch set with STAGES generic stage registers. Each register carries an opaque WIDTH-bit payload plus a valid bit, and supports per-stage stall with backward stall propagation, automatic bubble insertion, per-stage flush and a global memory-wait freeze. Saturating bubble and flush counters are included for hazard-unit debug. The block sits between the stage logic blocks (fetch, decode, execute, memory, writeback), which pack and unpack their control and data fields into the payload.

## Interface
Parameters:
- STAGES, 4, number of pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB); legal range 1..8
- WIDTH, 160, payload bits per register; unused upper bits tied to 0 by the producer
- CNT_W, 16, width of the debug counters

Ports (reset is synchronous, active-high; one clock):
- CLK  in  1  system clock, all state updates on the rising edge
- RST  in  1  synchronous active-high reset
- en  in  1  global advance enable (ihit/dhit qualified); 0 freezes all registers
- in_valid  in  1  valid for stage 0 input (fetched instruction present)
- d_in  in  STAGES*WIDTH  payload into register i at bits [i*WIDTH +: WIDTH]
- stall  in  STAGES  stall[i] requests that register i hold its contents
- flush  in  STAGES  flush[i] squashes register i
- q_valid  out  STAGES  valid bit of register i
- q_data  out  STAGES*WIDTH  payload of register i
- hold  out  STAGES  effective hold per register, fed back to stage logic and the PC
- bubble_cnt  out  CNT_W  saturating count of inserted bubbles
- flush_cnt  out  CNT_W  saturating count of flushes that killed a valid entry

## Operation
- Valid chain: the valid input of register 0 is in_valid; the valid input of register i>0 is q_valid[i-1]. Payload is always taken from d_in slice i.
- Effective hold: hold[STAGES-1] = stall[STAGES-1] | ~en. For i<STAGES-1, hold[i] = stall[i] | hold[i+1] | ~en. A stall therefore freezes that register and every register upstream of it.
- Per-register update, priority high to low:
  1. RST: valid←0, data←0.
  2. flush[i]: valid←0, data←0. Flush is applied even when hold[i] or ~en.
  3. hold[i]: hold current contents.
  4. i>0 and hold[i-1]: load a bubble (valid←0, data←0).
  5. Otherwise: valid←valid input, data←d_in slice.
- Bubble counting: bubble_cnt increments by the number of registers taking case 4 in that cycle. The sum is at most STAGES, and the counter saturates at all-ones and does not wrap.
- Flush counting: flush_cnt increments by the number of registers with flush[i]=1 and q_valid[i]=1 in that cycle, and saturates.
- A flush on an invalid register has no effect on flush_cnt.

## Timing
- Reset values: q_valid=0, q_data=0, bubble_cnt=0, flush_cnt=0. hold follows its combinational definition from stall and en.
- Latency is 1 cycle per register: d_in slice i sampled at edge N appears on q_data slice i after edge N.
- hold is purely combinational from stall and en, with no register in that path.
- Simultaneous stall[i] and flush[i]: the register clears (flush wins) and upstream registers still hold.
- Simultaneous flush[i] and a bubble condition: the register clears, and the bubble is counted only if flush is 0.
- RST asserted mid-stall or mid-freeze: all state clears on the next edge, and counters clear.
- en=0 together with RST=1: reset wins.
- A stall released at edge N: the held entry advances at edge N+1 and no duplicate entry is produced.

## Structure
- Add to cpu_types_pkg: the constants STAGE_IFID=0, STAGE_IDEX=1, STAGE_EXMEM=2, STAGE_MEMWB=3, and packed-struct typedefs ifid_t, idex_t, exmem_t and memwb_t. Stage logic casts these to and from the WIDTH-bit payload.
- Sub-module pipe_stage_reg holds one register: valid plus WIDTH bits, with the four-way priority above. pipe_reg_bank instantiates it STAGES times in a generate loop.
- The hold-chain logic and the counter adders stay in the top level.

## Test plan
- Reset and flow: RST for 2 cycles, then in_valid=1 with d_in slice 0 = 0x1 while en=1 → q_valid[0] rises 1 cycle after RST drops, and q_valid[3]=1 four cycles later. All outputs are 0 during reset.
- Load-use stall: stall[1]=1 for 1 cycle with registers 0..2 valid → hold=4'b0011, register 2 becomes a bubble, and bubble_cnt=1. Register 1 data is unchanged, and after release no entry is duplicated.
- Branch flush: flush=4'b0011 with both registers valid → q_valid[1:0]=0, q_data slices 0 and 1 = 0, and flush_cnt=2. Flushing the same registers again while they are invalid → flush_cnt stays 2.
- Stall and flush together: stall[2]=1 and flush[2]=1 → register 2 clears, hold=4'b0111, and register 3 takes a bubble.
- Freeze: en=0 for 5 cycles with changing d_in → all q_* are unchanged. A flush[3] pulse inside the freeze still clears register 3.
- Saturation: CNT_W=4, stall[0]=1 held for 20 cycles → bubble_cnt stops at 15. Then RST for 1 cycle → bubble_cnt=0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: stage indices, per-stage payload structs and
// small helpers used by the pipeline register bank.
package cpu_types_pkg;

  localparam int STAGE_IFID  = 0;
  localparam int STAGE_IDEX  = 1;
  localparam int STAGE_EXMEM = 2;
  localparam int STAGE_MEMWB = 3;

  // Default payload width; every stage struct below must fit inside it.
  localparam int PAYLOAD_W = 160;

  typedef struct packed {
    logic [31:0] pc_plus4;
    logic [31:0] instr;
  } ifid_t;

  typedef struct packed {
    logic [31:0] pc_plus4;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic        reg_dst;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        reg_write;
    logic        branch;
    logic        jump;
  } idex_t;

  typedef struct packed {
    logic [31:0] branch_target;
    logic [31:0] alu_out;
    logic [31:0] rt_data;
    logic [4:0]  wsel;
    logic        zero;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        reg_write;
    logic        branch;
  } exmem_t;

  typedef struct packed {
    logic [31:0] alu_out;
    logic [31:0] mem_data;
    logic [4:0]  wsel;
    logic        mem_to_reg;
    logic        reg_write;
  } memwb_t;

  // Population count over up to eight per-stage event flags.
  function automatic logic [3:0] count_ones(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/pipe_reg_bank_stage.sv
// One pipeline register: valid bit plus opaque payload, with
// flush > hold > bubble > load priority under synchronous reset.
module pipe_stage_reg #(
  parameter int WIDTH = 160
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             flush,
  input  logic             hold,
  input  logic             bubble,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             valid_reg;
  logic [WIDTH-1:0] data_reg;

  always_ff @(posedge clk) begin
    if (srst || flush) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (hold) begin
      valid_reg <= valid_reg;
      data_reg  <= data_reg;
    end else if (bubble) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else begin
      valid_reg <= valid_in;
      data_reg  <= data_in;
    end
  end

  assign valid = valid_reg;
  assign data  = data_reg;

endmodule

// File: rtl/pipe_reg_bank.sv
// Bank of STAGES pipeline registers with backward stall propagation,
// bubble insertion, per-stage flush, global freeze and debug counters.
module pipe_reg_bank
  import cpu_types_pkg::*;
#(
  parameter int STAGES = 4,
  parameter int WIDTH  = PAYLOAD_W,
  parameter int CNT_W  = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    en,
  input  logic                    in_valid,
  input  logic [STAGES*WIDTH-1:0] d_in,
  input  logic [STAGES-1:0]       stall,
  input  logic [STAGES-1:0]       flush,
  output logic [STAGES-1:0]       q_valid,
  output logic [STAGES*WIDTH-1:0] q_data,
  output logic [STAGES-1:0]       hold,
  output logic [CNT_W-1:0]        bubble_cnt,
  output logic [CNT_W-1:0]        flush_cnt
);

  logic [STAGES-1:0] valid_chain;
  logic [STAGES-1:0] up_hold;
  logic [STAGES-1:0] bubble_take;
  logic [STAGES-1:0] flush_kill;

  // A stall at stage i freezes everything upstream, so accumulate from the tail.
  always_comb begin
    logic acc;
    acc  = 1'b0;
    hold = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      acc     = acc | stall[i] | ~en;
      hold[i] = acc;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign valid_chain[gi] = in_valid;
        assign up_hold[gi]     = 1'b0;
      end else begin : g_body
        assign valid_chain[gi] = q_valid[gi-1];
        assign up_hold[gi]     = hold[gi-1];
      end

      // A flushed register is never counted as a bubble.
      assign bubble_take[gi] = up_hold[gi] & ~hold[gi] & ~flush[gi];
      assign flush_kill[gi]  = flush[gi] & q_valid[gi];

      pipe_stage_reg #(
        .WIDTH(WIDTH)
      ) u_stage (
        .clk     (CLK),
        .srst    (RST),
        .flush   (flush[gi]),
        .hold    (hold[gi]),
        .bubble  (up_hold[gi]),
        .valid_in(valid_chain[gi]),
        .data_in (d_in[gi*WIDTH +: WIDTH]),
        .valid   (q_valid[gi]),
        .data    (q_data[gi*WIDTH +: WIDTH])
      );
    end
  endgenerate

  logic [CNT_W-1:0] bubble_cnt_reg, bubble_cnt_next;
  logic [CNT_W-1:0] flush_cnt_reg, flush_cnt_next;
  logic [7:0]       bubble_pad, flush_pad;
  logic [CNT_W+3:0] bubble_sum, flush_sum;

  localparam logic [CNT_W+3:0] CNT_MAX = {4'b0000, {CNT_W{1'b1}}};

  // Four guard bits hold the per-cycle increment (at most 8) without wrap.
  always_comb begin
    bubble_pad = '0;
    flush_pad  = '0;
    bubble_pad[STAGES-1:0] = bubble_take;
    flush_pad[STAGES-1:0]  = flush_kill;
    bubble_sum = {4'b0000, bubble_cnt_reg} + {{CNT_W{1'b0}}, count_ones(bubble_pad)};
    flush_sum  = {4'b0000, flush_cnt_reg} + {{CNT_W{1'b0}}, count_ones(flush_pad)};
    bubble_cnt_next = (bubble_sum > CNT_MAX) ? {CNT_W{1'b1}} : bubble_sum[CNT_W-1:0];
    flush_cnt_next  = (flush_sum > CNT_MAX) ? {CNT_W{1'b1}} : flush_sum[CNT_W-1:0];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      bubble_cnt_reg <= '0;
      flush_cnt_reg  <= '0;
    end else begin
      bubble_cnt_reg <= bubble_cnt_next;
      flush_cnt_reg  <= flush_cnt_next;
    end
  end

  assign bubble_cnt = bubble_cnt_reg;
  assign flush_cnt  = flush_cnt_reg;

endmodule

// File: tb/tb_pipe_reg_bank.sv
// Table-driven bench for pipe_reg_bank with a behavioural model feeding a
// scoreboard queue; multi-cycle saturation handled as a hand sequence.
module tb_pipe_reg_bank;

  localparam int ST = 4;
  localparam int W  = 16;
  localparam int CW = 4;

  logic            CLK = 1'b0;
  logic            RST, en, in_valid;
  logic [ST*W-1:0] d_in;
  logic [ST-1:0]   stall, flush;
  logic [ST-1:0]   q_valid, hold;
  logic [ST*W-1:0] q_data;
  logic [CW-1:0]   bubble_cnt, flush_cnt;

  always #5 CLK = ~CLK;

  pipe_reg_bank #(.STAGES(ST), .WIDTH(W), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .en(en), .in_valid(in_valid), .d_in(d_in),
    .stall(stall), .flush(flush), .q_valid(q_valid), .q_data(q_data),
    .hold(hold), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct {
    logic        rst, en, iv;
    logic [3:0]  stall, flush;
    logic [11:0] base;
    logic [3:0]  exp_valid, exp_hold;
    int          exp_b, exp_f;
  } vec_t;

  typedef struct {
    logic [ST-1:0]   valid;
    logic [ST*W-1:0] data;
    int              b, f;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];

  logic [ST-1:0]   m_valid = '0;
  logic [ST*W-1:0] m_data  = '0;
  int              m_b = 0, m_f = 0;
  int              checks = 0, errors = 0, txn = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (txn %0d): got %0h expected %0h", name, txn, act, exp);
    end
  endfunction

  function automatic void add(logic rst, logic e, logic iv, logic [3:0] st, logic [3:0] fl,
                              logic [11:0] base, logic [3:0] ev, logic [3:0] eh, int eb, int ef);
    vec_t v;
    v.rst = rst; v.en = e; v.iv = iv; v.stall = st; v.flush = fl; v.base = base;
    v.exp_valid = ev; v.exp_hold = eh; v.exp_b = eb; v.exp_f = ef;
    vecs.push_back(v);
  endfunction

  // Drive one cycle of inputs, check hold combinationally, advance the model.
  task automatic drive(input vec_t v, input bit use_tbl);
    logic [ST-1:0]   h, old_v;
    logic [ST*W-1:0] old_d;
    logic            acc;
    int              nb, nf;
    sb_t             e;
    @(negedge CLK);
    RST = v.rst; en = v.en; in_valid = v.iv; stall = v.stall; flush = v.flush;
    for (int i = 0; i < ST; i++) d_in[i*W +: W] = {4'(i), v.base};
    acc = 1'b0;
    for (int i = ST - 1; i >= 0; i--) begin
      acc  = acc | v.stall[i] | ~v.en;
      h[i] = acc;
    end
    #1;
    chk("hold_model", 64'(hold), 64'(h));
    if (use_tbl) chk("hold_table", 64'(hold), 64'(v.exp_hold));
    old_v = m_valid; old_d = m_data; nb = 0; nf = 0;
    for (int i = 0; i < ST; i++) begin
      if (v.rst || v.flush[i]) begin
        if (!v.rst && v.flush[i] && old_v[i]) nf++;
        m_valid[i] = 1'b0; m_data[i*W +: W] = '0;
      end else if (h[i]) begin
        m_valid[i] = old_v[i]; m_data[i*W +: W] = old_d[i*W +: W];
      end else if (i > 0 && h[i-1]) begin
        nb++;
        m_valid[i] = 1'b0; m_data[i*W +: W] = '0;
      end else begin
        m_valid[i] = (i == 0) ? v.iv : old_v[i-1];
        m_data[i*W +: W] = d_in[i*W +: W];
      end
    end
    if (v.rst) begin
      m_b = 0; m_f = 0;
    end else begin
      m_b = (m_b + nb > 15) ? 15 : m_b + nb;
      m_f = (m_f + nf > 15) ? 15 : m_f + nf;
    end
    e.valid = m_valid; e.data = m_data; e.b = m_b; e.f = m_f;
    sb.push_back(e);
  endtask

  task automatic observe(input vec_t v, input bit use_tbl);
    sb_t e;
    @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk("q_valid", 64'(q_valid), 64'(e.valid));
      chk("q_data", 64'(q_data), 64'(e.data));
      chk("bubble_cnt", 64'(bubble_cnt), 64'(e.b));
      chk("flush_cnt", 64'(flush_cnt), 64'(e.f));
    end
    if (use_tbl) begin
      chk("q_valid_table", 64'(q_valid), 64'(v.exp_valid));
      chk("bubble_table", 64'(bubble_cnt), 64'(v.exp_b));
      chk("flush_table", 64'(flush_cnt), 64'(v.exp_f));
    end
    $display("txn %0d: rst=%0b en=%0b stall=%b flush=%b -> q_valid=%b hold=%b bcnt=%0d fcnt=%0d",
             txn, v.rst, v.en, v.stall, v.flush, q_valid, hold, bubble_cnt, flush_cnt);
    txn++;
  endtask

  task automatic step(input vec_t v, input bit use_tbl);
    drive(v, use_tbl);
    observe(v, use_tbl);
  endtask

  initial begin
    vec_t v;
    RST = 1'b1; en = 1'b1; in_valid = 1'b0; stall = '0; flush = '0; d_in = '0;

    //   rst en iv stall    flush    base    valid    hold     b  f
    add(1, 1, 0, 4'b0000, 4'b0000, 12'h000, 4'b0000, 4'b0000, 0, 0);
    add(1, 1, 0, 4'b0000, 4'b0000, 12'h000, 4'b0000, 4'b0000, 0, 0);
    add(0, 1, 1, 4'b0000, 4'b0000, 12'h001, 4'b0001, 4'b0000, 0, 0);
    add(0, 1, 1, 4'b0000, 4'b0000, 12'h002, 4'b0011, 4'b0000, 0, 0);
    add(0, 1, 1, 4'b0000, 4'b0000, 12'h003, 4'b0111, 4'b0000, 0, 0);
    add(0, 1, 1, 4'b0000, 4'b0000, 12'h004, 4'b1111, 4'b0000, 0, 0);
    add(0, 1, 1, 4'b0010, 4'b0000, 12'h005, 4'b1011, 4'b0011, 1, 0);
    add(0, 1, 1, 4'b0000, 4'b0000, 12'h006, 4'b0111, 4'b0000, 1, 0);
    add(0, 1, 1, 4'b0000, 4'b0011, 12'h007, 4'b1100, 4'b0000, 1, 2);
    add(0, 1, 1, 4'b0000, 4'b0011, 12'h008, 4'b1000, 4'b0000, 1, 2);
    add(0, 1, 1, 4'b0000, 4'b0000, 12'h009, 4'b0001, 4'b0000, 1, 2);
    add(0, 1, 1, 4'b0000, 4'b0000, 12'h00A, 4'b0011, 4'b0000, 1, 2);
    add(0, 1, 1, 4'b0000, 4'b0000, 12'h00B, 4'b0111, 4'b0000, 1, 2);
    add(0, 1, 1, 4'b0000, 4'b0000, 12'h00C, 4'b1111, 4'b0000, 1, 2);
    add(0, 1, 1, 4'b0100, 4'b0100, 12'h00D, 4'b0011, 4'b0111, 2, 3);
    add(0, 1, 1, 4'b0000, 4'b0000, 12'h00E, 4'b0111, 4'b0000, 2, 3);
    add(0, 1, 1, 4'b0000, 4'b0000, 12'h00F, 4'b1111, 4'b0000, 2, 3);
    add(0, 0, 1, 4'b0000, 4'b0000, 12'h0A1, 4'b1111, 4'b1111, 2, 3);
    add(0, 0, 0, 4'b0000, 4'b0000, 12'h0A2, 4'b1111, 4'b1111, 2, 3);
    add(0, 0, 1, 4'b0000, 4'b1000, 12'h0A3, 4'b0111, 4'b1111, 2, 4);
    add(0, 0, 0, 4'b0000, 4'b0000, 12'h0A4, 4'b0111, 4'b1111, 2, 4);
    add(0, 0, 1, 4'b0000, 4'b0000, 12'h0A5, 4'b0111, 4'b1111, 2, 4);
    add(0, 1, 0, 4'b0000, 4'b0000, 12'h010, 4'b1110, 4'b0000, 2, 4);
    add(1, 1, 1, 4'b0001, 4'b0000, 12'h011, 4'b0000, 4'b0001, 0, 0);
    add(1, 0, 1, 4'b0000, 4'b0000, 12'h012, 4'b0000, 4'b1111, 0, 0);

    foreach (vecs[k]) step(vecs[k], 1'b1);

    // Saturation: stage 1 takes a bubble every cycle while stage 0 stalls.
    for (int k = 1; k <= 20; k++) begin
      v.rst = 0; v.en = 1; v.iv = 1; v.stall = 4'b0001; v.flush = 4'b0000;
      v.base = 12'(12'h100 + k);
      step(v, 1'b0);
      chk("bubble_sat", 64'(bubble_cnt), 64'((k > 15) ? 15 : k));
    end
    v.rst = 1; v.en = 1; v.iv = 0; v.stall = 4'b0001; v.flush = 4'b0000; v.base = 12'h200;
    step(v, 1'b0);
    chk("bubble_after_rst", 64'(bubble_cnt), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
